// File: rtl/plru_arbiter.sv
// plru_arbiter: registered tree pseudo-LRU arbiter with a ready/ack handshake
// and optional burst lock. Grant outputs come only from registers.

// One internal tree node. The enable is one only on the node the winner walk
// passes through. It is steered into one child: the only child with a
// request, or the favoured child when both children have requests.
module plru_arbiter_node (
    input  logic en,
    input  logic l_any,
    input  logic r_any,
    input  logic fav,
    output logic sel_l,
    output logic sel_r
);
    logic go_r;

    // Go right when only the right subtree requests, or both request and right is favoured
    always_comb begin
        go_r  = r_any & (~l_any | fav);
        sel_l = en & ~go_r;
        sel_r = en & go_r;
    end
endmodule

module plru_arbiter #(
    parameter int WIDTH   = 4,
    parameter bit LOCK_EN = 1'b1,
    parameter int IDXW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    input  logic             lock,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0]  grant_idx,
    output logic             grant_valid,
    output logic [WIDTH-2:0] plru_state
);
    localparam int NODES = WIDTH - 1;
    localparam int TOT   = 2 * WIDTH - 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [NODES-1:0] tree_q, tree_d;
    logic [NODES-1:0] tree_upd;

    // Heap-ordered flags: nodes 0..NODES-1, then leaves NODES..TOT-1 (requesters 0..WIDTH-1)
    logic             any_v [TOT];
    logic             sel_c [TOT];   // winner walk on the current tree
    logic             sel_u [TOT];   // winner walk on the tree as updated by this handshake
    logic [IDXW-1:0]  win_c, win_u;
    logic             any_req;
    logic             lock_eff;

    assign any_req  = |req;
    assign lock_eff = LOCK_EN & lock;
    assign sel_c[0] = 1'b1;
    assign sel_u[0] = 1'b1;

    genvar gi, gl, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_leaf
            assign any_v[NODES+gi] = req[gi];
        end

        for (gi = 0; gi < NODES; gi++) begin : g_node
            assign any_v[gi] = any_v[2*gi+1] | any_v[2*gi+2];

            plru_arbiter_node u_cur (
                .en    (sel_c[gi]),
                .l_any (any_v[2*gi+1]),
                .r_any (any_v[2*gi+2]),
                .fav   (tree_q[gi]),
                .sel_l (sel_c[2*gi+1]),
                .sel_r (sel_c[2*gi+2])
            );

            plru_arbiter_node u_upd (
                .en    (sel_u[gi]),
                .l_any (any_v[2*gi+1]),
                .r_any (any_v[2*gi+2]),
                .fav   (tree_upd[gi]),
                .sel_l (sel_u[2*gi+1]),
                .sel_r (sel_u[2*gi+2])
            );
        end

        // The granted index picks one node per level. Those nodes are flipped to
        // point away from the grant. The top L index bits give the node at level L.
        for (gl = 0; gl < IDXW; gl++) begin : g_lvl
            for (gk = 0; gk < (1 << gl); gk++) begin : g_pos
                localparam int N = (1 << gl) - 1 + gk;
                if (gl == 0) begin : g_root
                    assign tree_upd[N] = ~idx_q[IDXW-1];
                end else begin : g_inner
                    assign tree_upd[N] = (idx_q[IDXW-1 -: gl] == gl'(gk)) ?
                                         ~idx_q[IDXW-1-gl] : tree_q[N];
                end
            end
        end
    endgenerate

    // Encode the one-hot leaf selections of both walks to binary indices
    always_comb begin
        win_c = '0;
        win_u = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_c[NODES+i]) win_c = win_c | IDXW'(i);
            if (sel_u[NODES+i]) win_u = win_u | IDXW'(i);
        end
    end

    // State register: FSM state, granted index and PLRU tree
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tree_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tree_q  <= tree_d;
        end
    end

    // Next state: grant from idle, hold, re-arbitrate after withdrawal, or update on handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tree_d  = tree_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_GRANT;
                    idx_d   = win_c;
                end
            end
            S_GRANT: begin
                if (ack) begin
                    if (!lock_eff) begin
                        // Regrant in the same cycle from the updated tree so back-to-back grants leave no gap
                        tree_d = tree_upd;
                        if (any_req) begin
                            idx_d = win_u;
                        end else begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end
                    end
                end else if (!req[idx_q]) begin
                    // Withdrawal: the tree is unchanged because no handshake completed
                    if (any_req) begin
                        idx_d = win_c;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs: decoded from registers only
    always_comb begin
        grant_valid = (state_q == S_GRANT);
        grant       = '0;
        grant_idx   = '0;
        if (grant_valid) begin
            grant[idx_q] = 1'b1;
            grant_idx    = idx_q;
        end
        plru_state = tree_q;
    end
endmodule

// File: tb/tb_plru_arbiter.sv
// tb_plru_arbiter: scenario tasks for plru_arbiter, WIDTH=4. One instance has
// LOCK_EN=1 and one has LOCK_EN=0, and both get the same stimulus. Expected
// grant indices are queued when stimulus is applied and popped when the grant appears.
module tb_plru_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       lock;

    logic [3:0] ga, gb;
    logic [1:0] ia, ib;
    logic       va, vb;
    logic [2:0] pa, pb;

    int checks   = 0;
    int failures = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    plru_arbiter #(.WIDTH(4), .LOCK_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .lock(lock),
        .grant(ga), .grant_idx(ia), .grant_valid(va), .plru_state(pa)
    );

    plru_arbiter #(.WIDTH(4), .LOCK_EN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .lock(lock),
        .grant(gb), .grant_idx(ib), .grant_valid(vb), .plru_state(pb)
    );

    // Advance one edge; outputs are sampled 1ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1; req = 4'b0000; ack = 1'b0; lock = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; ack = 1'b1; lock = 1'b1;
        tick();
        checks++;
        if (va !== 1'b0 || ga !== 4'b0000 || ia !== 2'd0 || pa !== 3'b000) begin
            failures++;
            $display("FAIL reset_a: got v=%b g=%b i=%0d p=%b, want v=0 g=0000 i=0 p=000", va, ga, ia, pa);
        end
        checks++;
        if (vb !== 1'b0 || gb !== 4'b0000 || ib !== 2'd0 || pb !== 3'b000) begin
            failures++;
            $display("FAIL reset_b: got v=%b g=%b i=%0d p=%b, want v=0 g=0000 i=0 p=000", vb, gb, ib, pb);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        int ea, eb;
        logic [3:0] eg;
        apply_reset();
        req = 4'b1111; ack = 1'b1; lock = 1'b0;
        qa = '{0, 2, 1, 3, 0, 2};
        qb = '{0, 2, 1, 3, 0, 2};
        tick();
        for (int k = 0; k < 6; k++) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            eg = 4'b0001 << ea;
            checks++;
            if (va !== 1'b1 || ia !== 2'(ea) || ga !== eg) begin
                failures++;
                $display("FAIL rr_a beat %0d: got v=%b i=%0d g=%b, want v=1 i=%0d g=%b", k, va, ia, ga, ea, eg);
            end
            checks++;
            if (vb !== 1'b1 || ib !== 2'(eb)) begin
                failures++;
                $display("FAIL rr_b beat %0d: got v=%b i=%0d, want v=1 i=%0d", k, vb, ib, eb);
            end
            if (k == 1) begin
                checks++;
                if (pa !== 3'b011) begin
                    failures++;
                    $display("FAIL rr_plru: got %b want 011", pa);
                end
            end
            tick();
        end
        // Final handshake with no requests left returns to idle
        req = 4'b0000;
        tick();
        checks++;
        if (va !== 1'b0 || ga !== 4'b0000 || ia !== 2'd0) begin
            failures++;
            $display("FAIL rr_idle: got v=%b g=%b i=%0d, want v=0 g=0000 i=0", va, ga, ia);
        end
    endtask

    task automatic test_hold;
        int ea;
        apply_reset();
        req = 4'b0100; ack = 1'b0; lock = 1'b0;
        qa = '{2, 2, 2};
        tick();
        for (int k = 0; k < 3; k++) begin
            ea = qa.pop_front();
            checks++;
            if (va !== 1'b1 || ia !== 2'(ea) || ga !== 4'b0100 || pa !== 3'b000) begin
                failures++;
                $display("FAIL hold cycle %0d: got v=%b i=%0d g=%b p=%b, want v=1 i=%0d g=0100 p=000",
                         k, va, ia, ga, pa, ea);
            end
            tick();
        end
    endtask

    task automatic test_lock;
        int ea, eb;
        logic [2:0] ep;
        apply_reset();
        req = 4'b1111; ack = 1'b1; lock = 1'b1;
        qa = '{0, 0, 0, 0, 2};
        qb = '{0, 2, 1, 3, 0};
        tick();
        for (int k = 0; k < 5; k++) begin
            lock = (k < 3);
            ea = qa.pop_front();
            eb = qb.pop_front();
            ep = (k < 4) ? 3'b000 : 3'b011;
            checks++;
            if (va !== 1'b1 || ia !== 2'(ea) || pa !== ep) begin
                failures++;
                $display("FAIL lock_a beat %0d: got i=%0d p=%b, want i=%0d p=%b", k, ia, pa, ea, ep);
            end
            checks++;
            if (vb !== 1'b1 || ib !== 2'(eb)) begin
                failures++;
                $display("FAIL lock_ignored_b beat %0d: got i=%0d, want i=%0d", k, ib, eb);
            end
            tick();
        end
    endtask

    task automatic test_withdraw;
        apply_reset();
        req = 4'b0101; ack = 1'b0; lock = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (va !== 1'b1 || ia !== 2'd2 || pa !== 3'b011) begin
            failures++;
            $display("FAIL wd_setup: got v=%b i=%0d p=%b, want v=1 i=2 p=011", va, ia, pa);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (va !== 1'b1 || ia !== 2'd0 || ga !== 4'b0001 || pa !== 3'b011) begin
            failures++;
            $display("FAIL wd_switch: got v=%b i=%0d g=%b p=%b, want v=1 i=0 g=0001 p=011", va, ia, ga, pa);
        end
        req = 4'b0100;
        tick();
        checks++;
        if (va !== 1'b1 || ia !== 2'd2 || pa !== 3'b011) begin
            failures++;
            $display("FAIL wd_back: got v=%b i=%0d p=%b, want v=1 i=2 p=011", va, ia, pa);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (va !== 1'b0 || ga !== 4'b0000 || ia !== 2'd0 || pa !== 3'b011) begin
            failures++;
            $display("FAIL wd_idle: got v=%b g=%b i=%0d p=%b, want v=0 g=0000 i=0 p=011", va, ga, ia, pa);
        end
    endtask

    task automatic test_back_to_back;
        int ea;
        logic [2:0] ep;
        apply_reset();
        req = 4'b0010; ack = 1'b1; lock = 1'b0;
        qa = '{1, 1, 1, 1};
        tick();
        for (int k = 0; k < 4; k++) begin
            ea = qa.pop_front();
            ep = (k == 0) ? 3'b000 : 3'b001;
            checks++;
            if (va !== 1'b1 || ia !== 2'(ea) || ga !== 4'b0010 || pa !== ep) begin
                failures++;
                $display("FAIL single beat %0d: got v=%b i=%0d g=%b p=%b, want v=1 i=%0d g=0010 p=%b",
                         k, va, ia, ga, pa, ea, ep);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        req = 4'b1111; ack = 1'b1; lock = 1'b0;
        tick();
        tick();
        lock = 1'b1;
        tick();
        checks++;
        if (va !== 1'b1 || ia !== 2'd2 || pa !== 3'b011) begin
            failures++;
            $display("FAIL burst_setup: got v=%b i=%0d p=%b, want v=1 i=2 p=011", va, ia, pa);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (va !== 1'b0 || ga !== 4'b0000 || ia !== 2'd0 || pa !== 3'b000) begin
            failures++;
            $display("FAIL burst_rst: got v=%b g=%b i=%0d p=%b, want v=0 g=0000 i=0 p=000", va, ga, ia, pa);
        end
        rst = 1'b0; lock = 1'b0; ack = 1'b0; req = 4'b1111;
        tick();
        checks++;
        if (va !== 1'b1 || ia !== 2'd0 || ga !== 4'b0001) begin
            failures++;
            $display("FAIL burst_regrant: got v=%b i=%0d g=%b, want v=1 i=0 g=0001", va, ia, ga);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; ack = 1'b0; lock = 1'b0;
        test_reset();
        test_round_robin();
        test_hold();
        test_lock();
        test_withdraw();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plru_arbiter.md
# plru_arbiter

Sequential tree pseudo-LRU arbiter for WIDTH requesters, WIDTH a power of two. It is a registered grant stage with a per-node PLRU state tree and a ready/ack handshake. An optional lock mode holds the grant across multi-beat bursts. It generalises the combinational PLRU-to-priority-matrix mapping in the arbiter library into a complete stateful arbiter.

## Interface
- WIDTH, 4: number of requesters; power of two, ≥2.
- LOCK_EN, 1: 1 = `lock` input honoured; 0 = `lock` ignored (treated as 0).
- IDXW, $clog2(WIDTH): grant index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  WIDTH  request vector, bit i = requester i.
- ack  in  1  consumer accepts current grant (handshake completes when grant_valid & ack).
- lock  in  1  sampled on handshake; 1 = keep grant on same requester for next beat.
- grant  out  WIDTH  one-hot registered grant; all-zero when grant_valid=0.
- grant_idx  out  IDXW  binary index of granted requester; 0 when grant_valid=0.
- grant_valid  out  1  grant registers hold a valid grant.
- plru_state  out  WIDTH-1  PLRU tree bits (debug/observability).

## Operation
- Tree: heap-indexed nodes, root = bit 0, children of node n = 2n+1 (left), 2n+2 (right); leaves map to requesters 0..WIDTH-1 left to right.
- Node bit 0 = left subtree favoured; 1 = right subtree favoured.
- Winner selection (combinational, from tree and req):
  - Walk from root.
  - At each node, if only one subtree has any req, take it.
  - If both subtrees have a req, take the favoured subtree.
- Tree update on a completing handshake with lock=0: every node on the winner's path is set to point away from the winner's subtree. Nodes off the path are unchanged.
- States:
  - IDLE (grant_valid=0): if |req, register winner → GRANT. Otherwise stay in IDLE.
  - GRANT (grant_valid=1, grant stable):
    - ack=0 and req[grant_idx]=1: hold; grant and tree unchanged.
    - ack=0 and req[grant_idx]=0 (withdrawal): tree unchanged. If other requests are present, register a new winner chosen from current req. Otherwise → IDLE.
    - ack=1 and (lock=1 with LOCK_EN=1): stay in GRANT on same index; tree unchanged (burst continues).
    - ack=1 and lock=0: update tree. The same edge registers a new winner chosen from current req using the *updated* tree, so there is no bubble. If req is all-zero → IDLE.
- grant, grant_idx and grant_valid change only at clock edges. Between edges they are never combinationally dependent on req, ack or lock.
- ack while grant_valid=0 is ignored.

## Timing
- Reset (rst=1 at edge) forces:
  - plru_state = 0
  - grant = 0, grant_idx = 0, grant_valid = 0
  - state IDLE
- Reset applies mid-burst and mid-handshake; the pending grant is discarded.
- Latency: req asserted in cycle N from IDLE → grant_valid=1 in cycle N+1.
- Throughput: one grant per cycle under continuous req and ack.
- Tree update takes effect at the handshake edge; plru_state reflects it in the following cycle.
- Single requester: it is re-granted every cycle while req stays high. The tree still updates on each unlocked handshake.

## Test plan
- Reset, WIDTH=4, req=1111, ack=1 continuously, lock=0 → grant_idx sequence 0,2,1,3,0,2,…. After the first handshake plru_state=3'b011.
- IDLE with req=0100 in cycle N, then ack=0 for 3 cycles → grant=0100 from N+1, stable for 3 cycles; plru_state remains 000.
- Grant on index 0 with req=1111, ack=1, lock=1 for 3 beats then lock=0 → grant_idx=0 for 4 beats. plru_state stays 000 until the final handshake, then 011; next grant_idx=2.
- LOCK_EN=0, same stimulus as above → lock ignored; sequence 0,2,1,3.
- Grant on index 2 (req=0101), then req drops to 0001 with ack=0 → next cycle grant_idx=0 and plru_state unchanged. With req=0000 instead → grant_valid=0.
- rst asserted during a locked burst → next cycle grant=0, grant_valid=0, plru_state=0. After rst deasserts with req=1111, the first grant_idx is 0.
